// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
// The clear controller and the storage top both import this package.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register file's write ports, read ports and ready flag.
// The master drives writes and read addresses; the slave returns data.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic                     wen0;
  logic                     wen1;
  logic [ADDR_W-1:0]        waddr0;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata0;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     ready;

  modport master (
    output wen0, wen1, waddr0, waddr1, wdata0, wdata1, raddr,
    input  rdata, ready
  );

  modport slave (
    input  wen0, wen1, waddr0, waddr1, wdata0, wdata1, raddr,
    output rdata, ready
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then holds RUN.
// ready is masked by rst so it drops in the same cycle reset is applied.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = RUN;
          ready_d   = 1'b1;
          clr_cnt_d = '0;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = clr_cnt_q;
  assign ready    = ready_q & ~rst;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with optional write-to-read forwarding
// and an optional hardwired-zero entry 0; contents are cleared after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              w0_en;
  logic              w1_en;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (run)
  );

  assign ready = run;

  // run already carries ~rst, so a write alongside reset is dropped here.
  assign w0_en = run & wen0 & ((ZERO_REG == 0) || (waddr0 != '0));
  assign w1_en = run & wen1 & ((ZERO_REG == 0) || (waddr1 != '0));

  // Port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (w0_en) mem_q[waddr0] <= wdata0;
      if (w1_en) mem_q[waddr1] <= wdata1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = mem_q[ra];
        if (BYPASS != 0) begin
          if (w1_en && (waddr1 == ra)) begin
            rd = wdata1;
          end else if (w0_en && (waddr0 == ra)) begin
            rd = wdata0;
          end
        end
        if (!run || ((ZERO_REG != 0) && (ra == '0))) begin
          rd = '0;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: a bypassing and a non-bypassing
// instance share one stimulus stream and are compared to an array-based model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  logic [NR*DW-1:0] rdata_nb;
  logic             ready_nb;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut_byp (
    .clk(clk), .rst(rst),
    .wen0(bus.wen0), .wen1(bus.wen1),
    .waddr0(bus.waddr0), .waddr1(bus.waddr1),
    .wdata0(bus.wdata0), .wdata1(bus.wdata1),
    .raddr(bus.raddr), .rdata(bus.rdata), .ready(bus.ready)
  );

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst(rst),
    .wen0(bus.wen0), .wen1(bus.wen1),
    .waddr0(bus.waddr0), .waddr1(bus.waddr1),
    .wdata0(bus.wdata0), .wdata1(bus.wdata1),
    .raddr(bus.raddr), .rdata(rdata_nb), .ready(ready_nb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            clr_done = 0;
  bit            ref_run  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Expected read: zero outside RUN or for entry 0, newest same-cycle write when forwarding.
  function automatic logic [DW-1:0] exp_read(input int lane, input bit byp);
    logic [AW-1:0] a;
    a = bus.raddr[lane*AW +: AW];
    if (rst || !ref_run || a == '0) return '0;
    if (byp) begin
      if (bus.wen1 && bus.waddr1 == a) return bus.wdata1;
      if (bus.wen0 && bus.waddr0 == a) return bus.wdata0;
    end
    return ref_mem[a];
  endfunction

  function automatic logic [DW-1:0] lane_byp(input int lane);
    return bus.rdata[lane*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] lane_nb(input int lane);
    return rdata_nb[lane*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  // Called at the negedge: generic checks, then the edge and the model update.
  task automatic tick(input string tag);
    chk({tag, ".ready_byp"}, 64'(bus.ready), 64'(ref_run && !rst));
    chk({tag, ".ready_nb"},  64'(ready_nb),  64'(ref_run && !rst));
    for (int l = 0; l < NR; l++) begin
      chk($sformatf("%s.byp%0d", tag, l), 64'(lane_byp(l)), 64'(exp_read(l, 1'b1)));
      chk($sformatf("%s.nb%0d",  tag, l), 64'(lane_nb(l)),  64'(exp_read(l, 1'b0)));
    end
    @(posedge clk);
    if (rst) begin
      ref_run  = 1'b0;
      clr_done = 0;
    end else if (!ref_run) begin
      clr_done++;
      if (clr_done == DEPTH) begin
        ref_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end else begin
      if (bus.wen0 && bus.waddr0 != '0) ref_mem[bus.waddr0] = bus.wdata0;
      if (bus.wen1 && bus.waddr1 != '0) ref_mem[bus.waddr1] = bus.wdata1;
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    settle();
    tick(tag);
  endtask

  task automatic set_w(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.wen0 = w0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.wen1 = w1; bus.waddr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic set_rnd();
    set_w(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
          1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    set_rd(rnd_addr(), rnd_addr());
  endtask

  // Walk the clear sequence with writes held, checking ready stays low for DEPTH cycles.
  task automatic clear_walk(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_rnd();
      bus.wen0 = 1'b1;
      bus.wen1 = 1'b1;
      settle();
      chk($sformatf("%s.ready_low%0d", tag, i), 64'(bus.ready), 64'd0);
      tick(tag);
    end
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    settle();
    chk({tag, ".ready_high"}, 64'(bus.ready), 64'd1);
    tick(tag);
    $display("txn %s: clear sequence done", tag);
  endtask

  task automatic read_all_zero(input string tag);
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      settle();
      chk($sformatf("%s.e%0d", tag, a),     64'(lane_byp(0)), 64'd0);
      chk($sformatf("%s.e%0d", tag, a + 1), 64'(lane_byp(1)), 64'd0);
      tick(tag);
    end
    $display("txn %s: all entries read back", tag);
  endtask

  initial begin
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    set_rd('0, '0);
    @(posedge clk);
    #1;

    // Power-up reset: one cycle high, then the clear walk.
    rst = 1'b1;
    set_rnd();
    settle();
    chk("rst.ready", 64'(bus.ready), 64'd0);
    tick("rst");
    rst = 1'b0;
    clear_walk("clr1");
    read_all_zero("rd1");

    // Dual write to distinct addresses.
    set_w(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
    set_rd(5'd1, 5'd2);
    cycle("dual_wr");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    set_rd(5'd3, 5'd7);
    settle();
    chk("dual.lane0", 64'(lane_byp(0)), 64'h1111_1111);
    chk("dual.lane1", 64'(lane_byp(1)), 64'h2222_2222);
    tick("dual_rd");
    $display("txn dual write 3/7");

    // Same-address collision: port 1 wins; both lanes see the same entry.
    set_w(1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd9, 32'h0000_BBBB);
    cycle("coll_wr");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    set_rd(5'd9, 5'd9);
    settle();
    chk("coll.lane0", 64'(lane_byp(0)), 64'h0000_BBBB);
    chk("coll.lane1", 64'(lane_byp(1)), 64'h0000_BBBB);
    tick("coll_rd");
    $display("txn collision on 9");

    // Forwarding versus old-value read.
    set_w(1'b1, 5'd5, 32'h1, 1'b0, '0, '0);
    set_rd(5'd0, 5'd0);
    cycle("byp_init");
    set_w(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    set_rd(5'd5, 5'd1);
    settle();
    chk("byp.fwd", 64'(lane_byp(0)), 64'hDEAD_BEEF);
    chk("byp.old", 64'(lane_nb(0)),  64'h1);
    tick("byp_wr");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    settle();
    chk("byp.after_fwd", 64'(lane_byp(0)), 64'hDEAD_BEEF);
    chk("byp.after_nb",  64'(lane_nb(0)),  64'hDEAD_BEEF);
    tick("byp_rd");
    $display("txn bypass on 5");

    // Entry 0 stays zero, forwarding included.
    set_w(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 5'd0);
    settle();
    chk("zero.same", 64'(lane_byp(0)), 64'd0);
    tick("zero_wr");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    settle();
    chk("zero.next", 64'(lane_byp(1)), 64'd0);
    tick("zero_rd");
    $display("txn zero register");

    // Reset again, then reset once more ten cycles into the clear.
    rst = 1'b1;
    set_rnd();
    cycle("rst2");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_rnd();
      bus.wen0 = 1'b1;
      cycle("clr_part");
    end
    rst = 1'b1;
    set_rnd();
    settle();
    chk("rst3.ready", 64'(bus.ready), 64'd0);
    tick("rst3");
    rst = 1'b0;
    clear_walk("clr2");
    read_all_zero("rd2");

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_rnd();
      cycle("rnd");
    end
    rst = 1'b0;
    $display("txn random traffic done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
